// File: rtl/rr_sel_arbiter4.sv
// Four-channel round-robin arbiter driving the 2-bit select of a 4:1 mux.
// Holds the grant until the downstream valid/ready handshake, then acks and rotates priority.
`timescale 1ns/1ps

module rr_sel_arbiter4 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    output logic [3:0]       in_ack,
    output logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] grant_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;

    logic             xfer;
    logic [3:0]       rest_mask;
    logic [1:0]       sel_plus1;

    // First set bit of mask, searching from position p upward with wrap.
    function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] p);
        logic [1:0] result;
        logic [1:0] idx;
        logic       found;
        result = p;
        found  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && mask[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    assign xfer      = (state_q == HOLD) && out_ready;
    assign sel_plus1 = sel_q + 2'd1;
    assign rest_mask = req & ~(4'b0001 << sel_q);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        grant_cnt_d = grant_cnt_q;
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    sel_d   = pick(req, ptr_q);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Served channel is excluded only for this re-arbitration, enabling back-to-back grants.
                if (xfer) begin
                    ptr_d       = sel_plus1;
                    grant_cnt_d = grant_cnt_q + CNT_W'(1);
                    if (rest_mask != 4'b0000) begin
                        sel_d = pick(rest_mask, sel_plus1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 2'b00;
            ptr_q       <= 2'b00;
            grant_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    always_comb begin
        in_ack = 4'b0000;
        if (xfer) begin
            in_ack[sel_q] = 1'b1;
        end
    end

    assign sel       = sel_q;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == HOLD);
    assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Directed self-checking bench for rr_sel_arbiter4; a second instance with a
// 2-bit counter shares the stimulus to exercise counter wrap.
`timescale 1ns/1ps

module tb_rr_sel_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;

    logic [3:0] in_ack;
    logic [1:0] sel;
    logic       out_valid;
    logic       busy;
    logic [7:0] grant_cnt;

    logic [3:0] in_ack2;
    logic [1:0] sel2;
    logic       out_valid2;
    logic       busy2;
    logic [1:0] grant_cnt2;

    int testCount = 0;
    int failCount = 0;
    int ackSeen[4];

    always #5 clk = ~clk;

    rr_sel_arbiter4 #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_ack    (in_ack),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .grant_cnt (grant_cnt)
    );

    rr_sel_arbiter4 #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_ack    (in_ack2),
        .sel       (sel2),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .busy      (busy2),
        .grant_cnt (grant_cnt2)
    );

    // Tally ack pulses at the edge where the handshake completes.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (in_ack[i]) ackSeen[i] = ackSeen[i] + 1;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkHold(input string tag, input logic [1:0] expSel, input logic [3:0] expAck);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_sel"}, 32'(sel), 32'(expSel));
        checkOutput({tag, "_ack"}, 32'(in_ack), 32'(expAck));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ackSeen[i] = 0;
        rst_n = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        step();

        // Reset state
        checkOutput("rst_sel", 32'(sel), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ack", 32'(in_ack), 32'd0);
        checkOutput("rst_cnt", 32'(grant_cnt), 32'd0);

        // Single request on ch2 with immediate ready
        rst_n = 1'b1;
        applyStimulus(4'b0100, 1'b1);
        step();
        checkHold("single", 2'd2, 4'b0100);
        checkOutput("single_busy", 32'(busy), 32'd1);
        applyStimulus(4'b0000, 1'b1);
        step();
        checkOutput("single_idle_valid", 32'(out_valid), 32'd0);
        checkOutput("single_idle_busy", 32'(busy), 32'd0);
        checkOutput("single_cnt", 32'(grant_cnt), 32'd1);
        checkOutput("single_sel_held", 32'(sel), 32'd2);
        checkOutput("single_idle_ack", 32'(in_ack), 32'd0);

        // Priority wrap: ptr=3, so ch3 beats ch0, then ch0 back-to-back
        applyStimulus(4'b1001, 1'b1);
        step();
        checkHold("wrap_first", 2'd3, 4'b1000);
        step();
        checkHold("wrap_second", 2'd0, 4'b0001);
        checkOutput("wrap_cnt2", 32'(grant_cnt), 32'd2);
        applyStimulus(4'b0000, 1'b1);
        step();
        checkOutput("wrap_idle_valid", 32'(out_valid), 32'd0);
        checkOutput("wrap_cnt3", 32'(grant_cnt), 32'd3);

        // ptr=1: grant ch1, then drop its request during stall; grant must persist
        applyStimulus(4'b0010, 1'b0);
        step();
        checkHold("drop_grant", 2'd1, 4'b0000);
        applyStimulus(4'b0000, 1'b0);
        step();
        checkHold("drop_stall1", 2'd1, 4'b0000);
        step();
        checkHold("drop_stall2", 2'd1, 4'b0000);
        applyStimulus(4'b0000, 1'b1);
        checkHold("drop_release", 2'd1, 4'b0010);
        step();
        checkOutput("drop_idle_valid", 32'(out_valid), 32'd0);
        checkOutput("drop_cnt", 32'(grant_cnt), 32'd4);

        // ptr=2: ch3 granted, then async reset mid-HOLD with ready high
        applyStimulus(4'b1000, 1'b0);
        step();
        checkHold("midrst_grant", 2'd3, 4'b0000);
        applyStimulus(4'b1000, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_sel", 32'(sel), 32'd0);
        checkOutput("midrst_cnt", 32'(grant_cnt), 32'd0);
        checkOutput("midrst_ack", 32'(in_ack), 32'd0);
        step();

        // Stall with req=0011 from reset, then release: ch0 then ch1
        applyStimulus(4'b0011, 1'b0);
        rst_n = 1'b1;
        step();
        checkHold("stall_grant", 2'd0, 4'b0000);
        for (int c = 0; c < 5; c++) begin
            step();
            checkHold($sformatf("stall_c%0d", c), 2'd0, 4'b0000);
        end
        applyStimulus(4'b0011, 1'b1);
        checkHold("stall_release", 2'd0, 4'b0001);
        step();
        checkHold("stall_next", 2'd1, 4'b0010);
        checkOutput("stall_cnt1", 32'(grant_cnt), 32'd1);
        applyStimulus(4'b0000, 1'b1);
        step();
        checkOutput("stall_idle_valid", 32'(out_valid), 32'd0);
        checkOutput("stall_cnt2", 32'(grant_cnt), 32'd2);

        // Ready while IDLE does nothing
        step();
        checkOutput("idle_ready_ack", 32'(in_ack), 32'd0);
        checkOutput("idle_ready_cnt", 32'(grant_cnt), 32'd2);
        checkOutput("idle_ready_valid", 32'(out_valid), 32'd0);

        // Fairness: all requests, continuous ready, from reset
        rst_n = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        step();
        for (int i = 0; i < 4; i++) ackSeen[i] = 0;
        rst_n = 1'b1;
        applyStimulus(4'b1111, 1'b1);
        step();
        for (int k = 0; k < 8; k++) begin
            checkHold($sformatf("fair_k%0d", k), 2'(k % 4), 4'(1 << (k % 4)));
            step();
            checkOutput($sformatf("fair_cnt_k%0d", k), 32'(grant_cnt), 32'(k + 1));
            checkOutput($sformatf("fair_cnt2_k%0d", k), 32'(grant_cnt2), 32'((k + 1) % 4));
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("fair_acks_ch%0d", i), 32'(ackSeen[i]), 32'd2);
        end
        checkHold("fair_after", 2'd0, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
